apb_master_ctrl: RTL and testbench

- APB master controller of the AHB-to-APB bridge; sits directly upstream of the APB bus.
- Drives paddr, pwdata, pwrite, penable and pselx[3:0], and samples prdata.
- Accepts decoded single transfers from the AHB-slave side through a valid/ready handshake and buffers them in a small request FIFO.
- Sequences each transfer through APB SETUP/ACCESS phases, with no pready (fixed two-cycle transfer), and returns a one-cycle response carrying read data or an error flag.

---
 rtl/apb_bridge_pkg.sv | 43 ++++
 rtl/apb_req_fifo.sv | 63 ++++++
 rtl/apb_master_ctrl.sv | 151 +++++++++++++++
 tb/tb_apb_master_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_bridge_pkg.sv
// -----------------------------------------------------------------------------
// apb_bridge_pkg
//   Shared types and constants for the APB master side of the AHB-to-APB
//   bridge: FSM state encoding, slave region map, select decoder and the
//   buffered request record.
// -----------------------------------------------------------------------------
package apb_bridge_pkg;

  localparam int PKG_ADDR_W = 32;
  localparam int PKG_DATA_W = 32;
  localparam int NUM_SLV    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ERR    = 2'd3
  } state_t;

  // Region tags compared against addr[31:26]; entry i selects pselx[i].
  localparam logic [NUM_SLV-1:0][5:0] SLV_BASE = {
    6'b100011,  // 0x8C00_0000 - 0x8FFF_FFFF
    6'b100010,  // 0x8800_0000 - 0x8BFF_FFFF
    6'b100001,  // 0x8400_0000 - 0x87FF_FFFF
    6'b100000   // 0x8000_0000 - 0x83FF_FFFF
  };

  // One-hot slave select for an address; all zeros means no slave owns it.
  function automatic logic [NUM_SLV-1:0] decode_sel(input logic [PKG_ADDR_W-1:0] addr);
    logic [NUM_SLV-1:0] sel;
    sel = '0;
    for (int i = 0; i < NUM_SLV; i++)
      if (addr[31:26] == SLV_BASE[i]) sel[i] = 1'b1;
    return sel;
  endfunction

  typedef struct packed {
    logic [PKG_ADDR_W-1:0] addr;
    logic [PKG_DATA_W-1:0] wdata;
    logic                  write;
  } req_t;

endpackage

// File: rtl/apb_req_fifo.sv
// -----------------------------------------------------------------------------
// apb_req_fifo
//   Synchronous show-ahead FIFO of request records between the AHB-slave
//   side and the APB sequencer.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push/wr_req: write the record when not full
//   pop/rd_req : rd_req always shows the head; pop advances when not empty
//   full/empty/count : occupancy status, count is log2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module apb_req_fifo
  import apb_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  req_t                   wr_req,
  input  logic                   pop,
  output req_t                   rd_req,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  req_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_req;
  end

  assign rd_req = mem[rd_ptr];
  assign full   = (count == (PW+1)'(DEPTH));
  assign empty  = (count == '0);

endmodule

// File: rtl/apb_master_ctrl.sv
// -----------------------------------------------------------------------------
// apb_master_ctrl
//   APB master of the AHB-to-APB bridge. Buffers single transfers offered on
//   a valid/ready interface, runs each one through APB SETUP and ACCESS
//   (fixed two cycles, no pready) and returns a one-cycle response.
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid/req_ready       : request handshake (ready = FIFO not full)
//   req_addr/wdata/write      : request payload
//   rsp_valid/rsp_rdata/rsp_err : response pulse, read data, no-slave flag
//   paddr/pwdata/pwrite/penable/pselx : registered APB outputs
//   prdata                    : APB read data, sampled at end of ACCESS
//   busy                      : transfer in progress or requests buffered
// -----------------------------------------------------------------------------
module apb_master_ctrl
  import apb_bridge_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_write,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              penable,
  output logic [3:0]        pselx,
  input  logic [DATA_W-1:0] prdata,
  output logic              busy
);

  state_t                 state;
  state_t                 state_nxt;
  req_t                   wr_req;
  req_t                   head;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  logic                   push;
  logic                   pop;
  logic [3:0]             head_sel;

  logic [ADDR_W-1:0]      paddr_nxt;
  logic [DATA_W-1:0]      pwdata_nxt;
  logic                   pwrite_nxt;
  logic                   penable_nxt;
  logic [3:0]             pselx_nxt;

  // No pop bypass: a full FIFO refuses even when the head leaves this cycle.
  assign req_ready = !full && !rst;
  assign push      = req_valid && req_ready;

  assign wr_req.addr  = req_addr;
  assign wr_req.wdata = req_wdata;
  assign wr_req.write = req_write;

  apb_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .wr_req (wr_req),
    .pop    (pop),
    .rd_req (head),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  assign head_sel = decode_sel(head.addr);

  // Next-state and next APB values. IDLE, ACCESS and ERR all end a slot, so
  // each may pop the head directly; that is what gives back-to-back SETUP.
  // paddr/pwdata/pwrite only load for a decodable head and otherwise hold.
  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    paddr_nxt   = paddr;
    pwdata_nxt  = pwdata;
    pwrite_nxt  = pwrite;
    penable_nxt = 1'b0;
    pselx_nxt   = 4'b0000;
    case (state)
      SETUP: begin
        state_nxt   = ACCESS;
        pselx_nxt   = pselx;
        penable_nxt = 1'b1;
      end
      IDLE, ACCESS, ERR: begin
        state_nxt = IDLE;
        if (!empty) begin
          pop = 1'b1;
          if (head_sel != 4'b0000) begin
            state_nxt  = SETUP;
            pselx_nxt  = head_sel;
            paddr_nxt  = head.addr;
            pwdata_nxt = head.wdata;
            pwrite_nxt = head.write;
          end else begin
            state_nxt = ERR;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      paddr   <= '0;
      pwdata  <= '0;
      pwrite  <= 1'b0;
      penable <= 1'b0;
      pselx   <= 4'b0000;
    end else begin
      state   <= state_nxt;
      paddr   <= paddr_nxt;
      pwdata  <= pwdata_nxt;
      pwrite  <= pwrite_nxt;
      penable <= penable_nxt;
      pselx   <= pselx_nxt;
    end
  end

  // Response is registered off the slot just finishing: ACCESS captures
  // prdata (reads only), ERR reports the unmapped address.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= (state == ACCESS) || (state == ERR);
      rsp_err   <= (state == ERR);
      rsp_rdata <= ((state == ACCESS) && !pwrite) ? prdata : '0;
    end
  end

  assign busy = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_apb_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_apb_master_ctrl
//   Self-checking bench. A transaction table schedules every accepted request
//   (pop edge, APB phases, response cycle) from the protocol's timing rules;
//   a compare process checks all DUT outputs against that schedule each cycle.
//   Directed scenarios add hand-computed literal checks.
//   Cycle k is the interval after rising edge k.
// -----------------------------------------------------------------------------
module tb_apb_master_ctrl;
  localparam int DEPTH = 4;
  localparam int MAXT  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_write = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        penable;
  logic [3:0]  pselx;
  logic [31:0] prdata = '0;
  logic        busy;

  always #5 clk = ~clk;

  apb_master_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .penable(penable),
    .pselx(pselx), .prdata(prdata), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rst_edge = -1;

  // transaction table
  logic [31:0] t_addr  [MAXT];
  logic [31:0] t_wdata [MAXT];
  logic        t_write [MAXT];
  int          t_e     [MAXT];
  int          t_p     [MAXT];
  bit          t_dead  [MAXT];
  int          nt = 0;
  int          free_edge = 0;

  logic [31:0] prd_hist [int];
  logic [31:0] prd_val = 32'h0;
  bit          prd_vary = 1'b0;

  logic [31:0] last_addr = '0;
  logic [31:0] last_wdata = '0;
  logic        last_write = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // Slave regions 0x8000_0000..0x8FFF_FFFF, 64 MiB each.
  function automatic logic [3:0] m_sel(input logic [31:0] a);
    if (a[31:28] != 4'h8) return 4'b0000;
    return 4'b0001 << a[27:26];
  endfunction

  function automatic int rsp_cyc(input int t);
    return t_p[t] + ((m_sel(t_addr[t]) != 4'b0) ? 2 : 1);
  endfunction

  function automatic int occ(input int k);
    int n;
    n = 0;
    for (int t = 0; t < nt; t++)
      if (!t_dead[t] && t_e[t] <= k && t_p[t] > k) n++;
    return n;
  endfunction

  // model update at each rising edge (inputs are stable here)
  always @(posedge clk) begin : edge_p
    int e;
    int p;
    e = cyc + 1;
    if (rst) begin
      for (int t = 0; t < nt; t++)
        if (!t_dead[t] && rsp_cyc(t) >= e) t_dead[t] = 1'b1;
      free_edge = 0;
      rst_edge = e;
    end else if (req_valid && occ(cyc) < DEPTH && nt < MAXT) begin
      t_addr[nt]  = req_addr;
      t_wdata[nt] = req_wdata;
      t_write[nt] = req_write;
      t_e[nt]     = e;
      t_dead[nt]  = 1'b0;
      p = (e + 1 > free_edge) ? e + 1 : free_edge;
      t_p[nt]     = p;
      free_edge   = p + ((m_sel(req_addr) != 4'b0) ? 2 : 1);
      nt++;
    end
    cyc = e;
  end

  always begin : prd_drv
    @(posedge clk);
    #1;
    prdata = prd_vary ? (prd_val ^ (32'(cyc) * 32'h0101_0101)) : prd_val;
    prd_hist[cyc] = prdata;
  end

  always @(negedge clk) begin : cmp_p
    logic [3:0]  e_sel;
    logic        e_en;
    logic        e_rv;
    logic        e_err;
    logic        e_busy;
    logic        v;
    logic [31:0] e_rd;
    if (cyc >= 1) begin
      e_sel = 4'b0; e_en = 1'b0; e_rv = 1'b0; e_err = 1'b0; e_busy = 1'b0; e_rd = '0;
      if (rst_edge == cyc) begin
        last_addr = '0; last_wdata = '0; last_write = 1'b0;
      end
      for (int t = 0; t < nt; t++) begin
        if (!t_dead[t]) begin
          v = (m_sel(t_addr[t]) != 4'b0);
          if (v && cyc == t_p[t]) begin
            e_sel = m_sel(t_addr[t]);
            last_addr = t_addr[t]; last_wdata = t_wdata[t]; last_write = t_write[t];
          end
          if (v && cyc == t_p[t] + 1) begin
            e_sel = m_sel(t_addr[t]);
            e_en = 1'b1;
          end
          if (cyc == rsp_cyc(t)) begin
            e_rv = 1'b1;
            e_err = !v;
            if (v && !t_write[t])
              e_rd = prd_hist.exists(t_p[t] + 1) ? prd_hist[t_p[t] + 1] : 32'hXXXX_XXXX;
          end
          if (t_e[t] <= cyc && cyc <= t_p[t] + (v ? 1 : 0)) e_busy = 1'b1;
        end
      end
      chk("pselx", 64'(pselx), 64'(e_sel));
      chk("penable", 64'(penable), 64'(e_en));
      chk("paddr", 64'(paddr), 64'(last_addr));
      chk("pwdata", 64'(pwdata), 64'(last_wdata));
      chk("pwrite", 64'(pwrite), 64'(last_write));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      if (e_rv) begin
        chk("rsp_err", 64'(rsp_err), 64'(e_err));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rd));
      end
      chk("busy", 64'(busy), 64'(e_busy));
      chk("req_ready", 64'(req_ready), 64'(!rst && occ(cyc) < DEPTH));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a request until accepted; acc returns the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic w, output int acc);
    int n;
    n = 0;
    req_addr = a; req_wdata = d; req_write = w; req_valid = 1'b1;
    while (!req_ready && n < 100) begin step(); n++; end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout cyc=%0d act=ready_low exp=accepted", cyc);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    step();
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) step();
  endtask

  logic [31:0] s_addr [8] = '{32'h8000_0000, 32'h8400_0000, 32'h8C00_0000, 32'h8800_0000,
                              32'h8000_0004, 32'h8400_0008, 32'h8C00_000C, 32'h8800_0010};
  logic        s_wr   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin : stim
    int acc;
    int sacc [8];
    rst = 1'b1;
    repeat (3) step();
    chk("reset_pselx", 64'(pselx), 64'h0);
    chk("reset_paddr", 64'(paddr), 64'h0);
    chk("reset_ready", 64'(req_ready), 64'h0);
    rst = 1'b0;
    step();

    // single write
    send(32'h8000_0010, 32'hDEAD_BEEF, 1'b1, acc);
    step();
    chk("wr_setup_sel", 64'(pselx), 64'h1);
    chk("wr_setup_en", 64'(penable), 64'h0);
    chk("wr_setup_addr", 64'(paddr), 64'h8000_0010);
    step();
    chk("wr_access_en", 64'(penable), 64'h1);
    chk("wr_access_pwrite", 64'(pwrite), 64'h1);
    chk("wr_access_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
    step();
    chk("wr_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("wr_rsp_err", 64'(rsp_err), 64'h0);
    chk("wr_rsp_rdata", 64'(rsp_rdata), 64'h0);
    step();
    chk("wr_rsp_pulse", 64'(rsp_valid), 64'h0);
    chk("wr_hold_addr", 64'(paddr), 64'h8000_0010);
    idle(2);

    // single read
    prd_val = 32'h1234_5678;
    send(32'h8800_0004, 32'h0, 1'b0, acc);
    step();
    chk("rd_setup_sel", 64'(pselx), 64'h4);
    step();
    chk("rd_access_en", 64'(penable), 64'h1);
    step();
    chk("rd_rsp_rdata", 64'(rsp_rdata), 64'h1234_5678);
    chk("rd_rsp_err", 64'(rsp_err), 64'h0);
    idle(2);

    // unmapped address
    send(32'h9000_0000, 32'h0, 1'b0, acc);
    step();
    chk("err_no_sel", 64'(pselx), 64'h0);
    chk("err_no_en", 64'(penable), 64'h0);
    step();
    chk("err_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("err_rsp_err", 64'(rsp_err), 64'h1);
    chk("err_rsp_rdata", 64'(rsp_rdata), 64'h0);
    idle(3);

    // eight back-to-back: FIFO fills, full-with-pop refuses, pointers wrap
    prd_val = 32'hA5C3_0000;
    prd_vary = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(s_addr[i], 32'h1000_0000 + 32'(i), s_wr[i], sacc[i]);
      if (i == 6) chk("stream_full_ready", 64'(req_ready), 64'h0);
    end
    chk("stream_first_six", 64'(sacc[6] - sacc[0]), 64'd6);
    chk("stream_full_refuse", 64'(sacc[7] - sacc[6]), 64'd2);
    idle(20);

    // valid / unmapped / valid streamed
    send(32'h8400_0020, 32'h0, 1'b0, acc);
    send(32'h7000_0000, 32'h0, 1'b1, acc);
    send(32'h8C00_0030, 32'h5555_AAAA, 1'b1, acc);
    idle(12);

    // reset during ACCESS of a read with two requests queued
    send(32'h8000_0020, 32'h0, 1'b0, acc);
    send(32'h8400_0024, 32'h1111_1111, 1'b1, acc);
    send(32'h8800_0028, 32'h0, 1'b0, acc);
    chk("pre_rst_access", 64'(penable), 64'h1);
    rst = 1'b1;
    step();
    chk("rst_sel", 64'(pselx), 64'h0);
    chk("rst_en", 64'(penable), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    rst = 1'b0;
    idle(4);
    send(32'h8C00_0040, 32'hCAFE_F00D, 1'b1, acc);
    step();
    chk("post_rst_sel", 64'(pselx), 64'h8);
    step();
    step();
    chk("post_rst_rsp", 64'(rsp_valid), 64'h1);
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc=%0d act=running exp=finished", cyc);
    $fatal(1);
  end

endmodule
